// File: rtl/cfg_txn_sequencer.sv
// Drives one register transaction at a time into a cfg slave, enforces the
// full enable/sack handshake and returns read data or a timeout response.
module cfg_txn_sequencer #(
   parameter int unsigned TIMEOUT_CYCLES = 255
) (
   input  logic        clock,
   input  logic        reset_n,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_write,
   input  logic [7:0]  req_addr,
   input  logic [31:0] req_data,
   output logic        rsp_valid,
   input  logic        rsp_ready,
   output logic [31:0] rsp_data,
   output logic        rsp_timeout,
   output logic [15:0] timeout_count,
   output logic [7:0]  cfg_addr,
   output logic [31:0] cfg_data_mwrite,
   output logic        cfg_mread_en,
   output logic        cfg_mwrite_en,
   input  logic [31:0] cfg_data_mread,
   input  logic        cfg_sack
);

   // state     | meaning
   // S_IDLE    | waiting for a command, req_ready high one cycle after entry
   // S_ISSUE   | one enable high, waiting for sack or wait-timer expiry
   // S_RELEASE | enables low, waiting for the slave to drop sack
   // S_RESPOND | response held on rsp_* until rsp_ready
   typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_RELEASE, S_RESPOND} state_t;

   localparam logic [15:0] WAIT_LAST = 16'(TIMEOUT_CYCLES - 1);

   state_t      state_q, state_d;
   logic        req_ready_q;
   logic        write_q;
   logic        rsp_timeout_q;
   logic [7:0]  addr_q;
   logic [31:0] wdata_q;
   logic [31:0] rsp_data_q;
   logic [15:0] wait_cnt_q;
   logic [15:0] timeout_cnt_q;
   logic        accept;
   logic        sack_hit;
   logic        expire;

   assign accept   = (state_q == S_IDLE) && req_valid && req_ready_q;
   assign sack_hit = (state_q == S_ISSUE) && cfg_sack;
   // Down-counter hits zero at the end of the last allowed ISSUE cycle.
   assign expire   = (state_q == S_ISSUE) && !cfg_sack && (wait_cnt_q == '0);

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) state_q <= S_IDLE;
      else          state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:    if (accept)               state_d = S_ISSUE;
         S_ISSUE:   if (sack_hit || expire)   state_d = S_RELEASE;
         S_RELEASE: if (!cfg_sack)            state_d = S_RESPOND;
         S_RESPOND: if (rsp_ready)            state_d = S_IDLE;
         default:                             state_d = S_IDLE;
      endcase
   end

   always_comb begin
      cfg_mread_en  = 1'b0;
      cfg_mwrite_en = 1'b0;
      rsp_valid     = 1'b0;
      case (state_q)
         S_ISSUE: begin
            cfg_mread_en  = !write_q;
            cfg_mwrite_en = write_q;
         end
         S_RESPOND: rsp_valid = 1'b1;
         default: ;
      endcase
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         req_ready_q   <= 1'b0;
         write_q       <= 1'b0;
         addr_q        <= '0;
         wdata_q       <= '0;
         rsp_data_q    <= '0;
         rsp_timeout_q <= 1'b0;
         wait_cnt_q    <= WAIT_LAST;
         timeout_cnt_q <= '0;
      end else begin
         // Ready follows IDLE by one cycle so a returning response never
         // overlaps a new accept.
         req_ready_q <= (state_q == S_IDLE) && !accept;
         if (accept) begin
            write_q <= req_write;
            addr_q  <= req_addr;
            wdata_q <= req_data;
         end
         if (state_q != S_ISSUE)
            wait_cnt_q <= WAIT_LAST;
         else if (!cfg_sack && wait_cnt_q != '0)
            wait_cnt_q <= wait_cnt_q - 16'd1;
         if (sack_hit) begin
            rsp_data_q    <= cfg_data_mread;
            rsp_timeout_q <= 1'b0;
         end else if (expire) begin
            rsp_data_q    <= '0;
            rsp_timeout_q <= 1'b1;
            if (timeout_cnt_q != 16'hFFFF)
               timeout_cnt_q <= timeout_cnt_q + 16'd1;
         end
      end
   end

   assign req_ready       = req_ready_q;
   assign rsp_data        = rsp_data_q;
   assign rsp_timeout     = rsp_timeout_q;
   assign timeout_count   = timeout_cnt_q;
   assign cfg_addr        = addr_q;
   assign cfg_data_mwrite = wdata_q;

endmodule

// File: doc/cfg_txn_sequencer.md
# cfg_txn_sequencer

Upstream driver for the generic register configuration interface. It accepts one register transaction at a time from the command decoder via valid/ready, drives `cfg_addr`/`cfg_data_mwrite`/`cfg_mread_en`/`cfg_mwrite_en` into a slave core such as the GPIO core, and waits for `cfg_sack`. It returns the captured read data, or a timeout indication, on a valid/ready response channel. It also enforces the full enable/sack handshake, so a slave always sees enable drop and sack drop before the next transaction starts.

## Interface
- `TIMEOUT_CYCLES`, default 255: maximum cycles the enable is held without `cfg_sack`; legal range 2..65535.
- `clock`  in  1  sole clock; all logic rising-edge.
- `reset_n`  in  1  asynchronous, active-low reset; one clock; reset is asynchronous and active-low.
- `req_valid`  in  1  command present.
- `req_ready`  out  1  sequencer idle, accepts command.
- `req_write`  in  1  1 = register write, 0 = read.
- `req_addr`  in  8  register address.
- `req_data`  in  32  write data (ignored for reads).
- `rsp_valid`  out  1  response present.
- `rsp_ready`  in  1  consumer takes response.
- `rsp_data`  out  32  `cfg_data_mread` captured at sack; 0 on timeout.
- `rsp_timeout`  out  1  transaction timed out.
- `timeout_count`  out  16  saturating count of timeouts since reset.
- `cfg_addr`  out  8  to slave.
- `cfg_data_mwrite`  out  32  to slave.
- `cfg_mread_en`  out  1  to slave.
- `cfg_mwrite_en`  out  1  to slave.
- `cfg_data_mread`  in  32  from slave.
- `cfg_sack`  in  1  from slave.

## Operation
- Reset values: all outputs 0, including `req_ready`; state IDLE. `req_ready` rises on the first rising edge after `reset_n` deasserts.
- IDLE: `req_ready`=1. When `req_valid`&`req_ready` (accept edge A), latch addr/data/write onto `cfg_addr`/`cfg_data_mwrite`, clear `req_ready`, and go to ISSUE.
- `cfg_addr`/`cfg_data_mwrite` hold the latched values until the next accept.
- ISSUE: exactly one enable is high, `cfg_mwrite_en` if write else `cfg_mread_en`; never both.
  - Wait counter is cleared on entry and increments each ISSUE cycle in which `cfg_sack` is 0.
  - `cfg_sack`=1 sampled: capture `cfg_data_mread`, set `rsp_timeout`=0, drop enable next cycle, go to RELEASE.
  - Counter reaches `TIMEOUT_CYCLES`-1 with `cfg_sack`=0: set `rsp_data`=0, `rsp_timeout`=1, increment `timeout_count` (saturating at 0xFFFF), drop enable, go to RELEASE.
  - Sack on the final allowed cycle counts as success.
- RELEASE: enables 0; wait until `cfg_sack` is sampled 0, then go to RESPOND. An already-low sack exits after one cycle.
- RESPOND: `rsp_valid`=1 with `rsp_data`/`rsp_timeout` stable. On `rsp_valid`&`rsp_ready`, clear `rsp_valid` and return to IDLE, where `req_ready` reasserts the following cycle.
- No overlap: one outstanding transaction. `req_valid` is ignored outside IDLE.
- Reset asserted mid-transaction: enables, `rsp_valid` and `req_ready` drop immediately (asynchronous); the pending command and response are discarded; `timeout_count` clears.

## Timing
- Accept at edge A; enable high in cycle A+1.
- With a slave that registers sack one cycle after enable, as the GPIO core does:
  - sack sampled at end of A+2;
  - enable low in A+3;
  - sack low in A+4;
  - `rsp_valid` high in cycle A+5.
- Timeout path: enable high for exactly `TIMEOUT_CYCLES` cycles; `rsp_valid` 2 cycles after enable drops when sack stays low.
- Minimum accept-to-accept spacing is 7 cycles with a 1-cycle slave and `rsp_ready` held high.
- Registered outputs only; no combinational path from any input to any output.

## Test plan
- Read addr 0x02 against a 1-cycle sack model returning 0x000000FF:
  - `cfg_mread_en` high exactly 2 cycles;
  - `rsp_valid` at A+5;
  - `rsp_data`=0x000000FF, `rsp_timeout`=0.
- Write addr 0x04, data 0x0000AB00:
  - only `cfg_mwrite_en` asserts;
  - `cfg_data_mwrite`=0x0000AB00 stable through ISSUE/RELEASE;
  - `rsp_data` equals the slave echo.
- `TIMEOUT_CYCLES`=8, slave never acks:
  - enable high exactly 8 cycles;
  - `rsp_timeout`=1, `rsp_data`=0, `timeout_count`=1.
  - Repeat 0x10000 times with a forced counter preload: `timeout_count` stays 0xFFFF.
- Sack first asserted on 8th ISSUE cycle (`TIMEOUT_CYCLES`=8): success, `rsp_timeout`=0, data captured, `timeout_count` unchanged.
- `rsp_ready` low for 10 cycles in RESPOND:
  - response stable;
  - `req_ready`=0;
  - `req_valid` pulses produce no enable;
  - after `rsp_ready`, next request accepted.
- `reset_n` low during ISSUE:
  - enable drops before the next clock edge;
  - after release, `req_ready`=1 on first edge, no stale `rsp_valid`, `timeout_count`=0.
